apb_cmd_master: RTL and testbench

//   APB initiator (requester) converting single-beat commands on a valid/ready

---
 rtl/apb_cmd_master.sv | 125 ++++++++++++
 tb/tb_apb_cmd_master.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: APB3 requester that turns single-beat valid/ready commands
// into APB transfers, one outstanding at a time, and returns read data plus
// an error flag on a valid/ready response port.
//   pclk, prstn            clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_write/cmd_addr/cmd_wdata payload
//   rsp_valid/rsp_ready    response handshake; rsp_rdata/rsp_err payload
//   psel..pslverr          APB3 requester interface
module apb_cmd_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              prstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  logic             timed_out;

  // Count including the current ACCESS cycle; timeout fires on the cycle
  // that makes TIMEOUT ACCESS cycles in total.
  assign cnt_inc   = {1'b0, cnt} + (CNT_W+1)'(1);
  assign timed_out = (TIMEOUT != 0) && (cnt_inc >= (CNT_W+1)'(TIMEOUT));

  assign cmd_ready = (state == IDLE);

  // Transfer sequencer with registered APB and response outputs.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state     <= IDLE;
      cnt       <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            pwdata  <= cmd_wdata;
            cnt     <= '0;
            state   <= SETUP;
          end
        end

        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          // Saturating so TIMEOUT=0 can wait indefinitely without wrapping.
          if (!(&cnt)) begin
            cnt <= cnt + CNT_W'(1);
          end
          if (pready || timed_out) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
            // pready wins over a coincident timeout.
            if (pready) begin
              rsp_err   <= pslverr;
              rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
            end else begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed and randomized checks of apb_cmd_master against
// a transaction-level reference (expected response per command from slave
// wait/error behaviour and a shadow memory).
module tb_apb_cmd_master;

  localparam int TMO = 16;

  logic        pclk = 1'b0;
  logic        prstn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_valid0 = 1'b0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic        cmd_ready0, rsp_valid0, rsp_err0, psel0, penable0, pwrite0;
  logic [31:0] rsp_rdata0, paddr0, pwdata0;
  logic        pready0 = 1'b0;

  // slave behaviour controls
  int          cur_wait = 0;
  logic        cur_err = 1'b0;
  logic        tie1 = 1'b0;

  int total = 0;
  int bad = 0;

  // slave / monitor state
  logic [31:0] mem     [16] = '{default: 32'h0};
  logic [31:0] ref_mem [16] = '{default: 32'h0};
  int          acc_cnt = 0, acc_seen = 0, unstable = 0, cyc = 0;
  logic [31:0] su_addr = '0, su_wdata = '0;
  logic        su_write = 1'b0;

  always #5 pclk = ~pclk;

  assign pready  = tie1 ? 1'b1 : (psel && penable && (acc_cnt == cur_wait));
  assign pslverr = cur_err;
  assign prdata  = mem[paddr[5:2]];

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .prstn(prstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut0 (
    .pclk(pclk), .prstn(prstn),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .psel(psel0), .penable(penable0), .pwrite(pwrite0), .paddr(paddr0), .pwdata(pwdata0),
    .prdata(prdata), .pready(pready0), .pslverr(pslverr)
  );

  // APB slave memory and protocol monitor
  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (psel && penable) acc_seen <= acc_seen + 1;
    if (psel && !penable) begin
      su_addr  <= paddr;
      su_wdata <= pwdata;
      su_write <= pwrite;
    end
    if (psel && penable && (paddr !== su_addr || pwdata !== su_wdata || pwrite !== su_write))
      unstable <= unstable + 1;
    if (psel && penable && pready && pwrite && !pslverr)
      mem[paddr[5:2]] <= pwdata;
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL cmd_accept got cmd_ready=%0b exp=1 after %0d cycles", cmd_ready, n);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 200) begin tick(); n++; end
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++; $display("FAIL rsp_wait got rsp_valid=%0b exp=1 after %0d cycles", rsp_valid, n);
    end
  endtask

  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int wt, input logic er, input int rdly);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_acc, a0, u0;
    cur_wait = wt; cur_err = er;
    if (wt >= TMO) begin
      exp_acc = TMO; exp_err = 1'b1; exp_rd = 32'h0;
    end else begin
      exp_acc = wt + 1; exp_err = er;
      exp_rd  = (w || er) ? 32'h0 : ref_mem[a[5:2]];
      if (w && !er) ref_mem[a[5:2]] = d;
    end
    a0 = acc_seen; u0 = unstable;
    send_cmd(w, a, d);
    wait_rsp();
    for (int i = 0; i < rdly; i++) begin
      tick();
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd) begin
        bad++; $display("FAIL rsp_hold got v=%0b d=%h exp v=1 d=%h", rsp_valid, rsp_rdata, exp_rd);
      end
    end
    total++;
    if (rsp_rdata !== exp_rd || rsp_err !== exp_err) begin
      bad++; $display("FAIL txn_rsp a=%h w=%0b wt=%0d er=%0b got d=%h e=%0b exp d=%h e=%0b",
                      a, w, wt, er, rsp_rdata, rsp_err, exp_rd, exp_err);
    end
    total++;
    if (acc_seen - a0 !== exp_acc || unstable - u0 !== 0 || su_addr !== a || su_write !== w) begin
      bad++; $display("FAIL txn_apb a=%h got acc=%0d unst=%0d addr=%h wr=%0b exp acc=%0d unst=0 addr=%h wr=%0b",
                      a, acc_seen - a0, unstable - u0, su_addr, su_write, exp_acc, a, w);
    end
    total++;
    if (psel !== 1'b0 || penable !== 1'b0 || paddr !== 32'h0) begin
      bad++; $display("FAIL txn_idle_bus got psel=%0b pen=%0b paddr=%h exp 0/0/0", psel, penable, paddr);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL txn_done got rsp_valid=%0b cmd_ready=%0b exp 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge pclk);
    #1;
    total++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0 || paddr !== 32'h0 ||
        pwdata !== 32'h0 || rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_outputs got psel=%0b pen=%0b pw=%0b rv=%0b re=%0b pa=%h pd=%h rd=%h exp all 0",
                      psel, penable, pwrite, rsp_valid, rsp_err, paddr, pwdata, rsp_rdata);
    end
    @(negedge pclk);
    prstn = 1'b1;
    tick();
    total++;
    if (cmd_ready !== 1'b1 || psel !== 1'b0) begin
      bad++; $display("FAIL reset_release got cmd_ready=%0b psel=%0b exp 1/0", cmd_ready, psel);
    end
  endtask

  task automatic test_write_latency();
    tie1 = 1'b1; cur_err = 1'b0;
    ref_mem[4] = 32'h55;
    send_cmd(1'b1, 32'h10, 32'h55);
    total++;
    if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 32'h10 || pwdata !== 32'h55 || pwrite !== 1'b1) begin
      bad++; $display("FAIL lat_setup got psel=%0b pen=%0b pa=%h pd=%h pw=%0b exp 1/0/10/55/1",
                      psel, penable, paddr, pwdata, pwrite);
    end
    tick();
    total++;
    if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 32'h10 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL lat_access got psel=%0b pen=%0b pa=%h rv=%0b exp 1/1/10/0", psel, penable, paddr, rsp_valid);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || psel !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL lat_resp got rv=%0b re=%0b rd=%h psel=%0b cr=%0b exp 1/0/0/0/0",
                      rsp_valid, rsp_err, rsp_rdata, psel, cmd_ready);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tie1 = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL lat_done got rv=%0b cr=%0b exp 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read_wait();
    run_txn(1'b1, 32'h14, 32'hA5, 0, 1'b0, 0);
    run_txn(1'b0, 32'h14, 32'h0, 3, 1'b0, 2);
  endtask

  task automatic test_slverr();
    run_txn(1'b1, 32'h18, 32'h12, 0, 1'b0, 0);
    run_txn(1'b0, 32'h18, 32'h0, 0, 1'b1, 0);
    run_txn(1'b1, 32'h18, 32'h99, 1, 1'b1, 0);
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 32'h1C, 32'h0, 1 << 30, 1'b0, 1);
    run_txn(1'b1, 32'h20, 32'h3, TMO - 1, 1'b0, 0);
    run_txn(1'b1, 32'h24, 32'h4, TMO, 1'b0, 0);
  endtask

  task automatic test_timeout0();
    cur_err = 1'b0; pready0 = 1'b0;
    cmd_write = 1'b0; cmd_addr = 32'h30; cmd_valid0 = 1'b1;
    tick();
    cmd_valid0 = 1'b0;
    repeat (1000) tick();
    total++;
    if (psel0 !== 1'b1 || penable0 !== 1'b1 || rsp_valid0 !== 1'b0 || paddr0 !== 32'h30) begin
      bad++; $display("FAIL notimeout_wait got psel=%0b pen=%0b rv=%0b pa=%h exp 1/1/0/30",
                      psel0, penable0, rsp_valid0, paddr0);
    end
    pready0 = 1'b1;
    tick();
    pready0 = 1'b0;
    total++;
    if (rsp_valid0 !== 1'b1 || rsp_err0 !== 1'b0 || psel0 !== 1'b0) begin
      bad++; $display("FAIL notimeout_done got rv=%0b re=%0b psel=%0b exp 1/0/0", rsp_valid0, rsp_err0, psel0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    cur_wait = 1; cur_err = 1'b0;
    send_cmd(1'b0, 32'h14, 32'h0);
    wait_rsp();
    cmd_write = 1'b1; cmd_addr = 32'h28; cmd_wdata = 32'h77; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[5] || cmd_ready !== 1'b0 || psel !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got rv=%0b rd=%h cr=%0b psel=%0b exp 1/%h/0/0",
                        i, rsp_valid, rsp_rdata, cmd_ready, psel, ref_mem[5]);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if (cmd_ready !== 1'b1 || psel !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got cr=%0b psel=%0b rv=%0b exp 1/0/0", cmd_ready, psel, rsp_valid);
    end
    cur_wait = 0;
    tick();
    cmd_valid = 1'b0;
    total++;
    if (psel !== 1'b1 || paddr !== 32'h28 || pwrite !== 1'b1 || pwdata !== 32'h77) begin
      bad++; $display("FAIL bp_queued got psel=%0b pa=%h pw=%0b pd=%h exp 1/28/1/77", psel, paddr, pwrite, pwdata);
    end
    ref_mem[10] = 32'h77;
    wait_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int last = 0;
    cur_wait = 0; cur_err = 1'b0; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int n = 0;
      cmd_write = 1'b1; cmd_addr = 32'h40 + 32'(k * 4); cmd_wdata = 32'hB0 + 32'(k); cmd_valid = 1'b1;
      while (!cmd_ready && n < 20) begin tick(); n++; end
      tick();
      ref_mem[4'(k)] = 32'hB0 + 32'(k);
      if (k > 0) begin
        total++;
        if (cyc - last !== 4) begin
          bad++; $display("FAIL b2b_spacing k=%0d got=%0d exp=4", k, cyc - last);
        end
      end
      last = cyc;
    end
    cmd_valid = 1'b0;
    repeat (5) tick();
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) run_txn(1'b0, 32'h40 + 32'(k * 4), 32'h0, k, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    cur_wait = 1 << 30; cur_err = 1'b0;
    send_cmd(1'b1, 32'h3C, 32'hDEAD);
    repeat (3) tick();
    #2 prstn = 1'b0;
    #1;
    total++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid got psel=%0b pen=%0b rv=%0b cr=%0b exp 0/0/0/1", psel, penable, rsp_valid, cmd_ready);
    end
    @(negedge pclk);
    prstn = 1'b1;
    tick();
    run_txn(1'b1, 32'h2C, 32'h1234, 2, 1'b0, 1);
    run_txn(1'b0, 32'h3C, 32'h0, 0, 1'b0, 0);
    run_txn(1'b0, 32'h2C, 32'h0, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic        w;
      logic [31:0] a;
      w = 1'($urandom_range(0, 1));
      a = $urandom;
      run_txn(w, a, $urandom, int'($urandom_range(0, 20)), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_timeout0();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
